// File: rtl/opb_register_ppc2simulink.sv
// OPB slave control register: PPC writes a staging word, a commit (explicit or automatic)
// transfers it atomically to user_data_out with a one-cycle strobe.
module opb_register_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h01028200,
  parameter logic [31:0] C_HIGHADDR    = 32'h010282FF,
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex6",
  parameter logic [31:0] C_INIT_VALUE  = 32'h00000000,
  parameter bit          C_AUTO_COMMIT = 1'b0
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        Sl_xferAck,
  output logic [31:0] user_data_out,
  output logic        user_data_strobe
);

  typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

  state_e      state_q, state_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] user_q, user_d;
  logic [15:0] cnt_q, cnt_d;
  logic        strobe_q, strobe_d;
  logic        rnw_q, rnw_d;
  logic        is_stage_q, is_stage_d;
  logic        is_cmd_q, is_cmd_d;

  logic [31:0] addr, off, wdata, merged, rdata;
  logic [3:0]  be;
  logic        hit, commit, ack;
  logic        unused_cfg;

  // Big-endian OPB numbering maps MSB-first onto little-endian vectors.
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign off   = addr - C_BASEADDR;
  assign hit   = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign unused_cfg = ^{OPB_seqAddr, off[1:0], (C_FAMILY == ""), (C_OPB_AWIDTH != 32),
                        (C_OPB_DWIDTH != 32)};

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    user_d     = user_q;
    cnt_d      = cnt_q;
    strobe_d   = 1'b0;
    rnw_d      = rnw_q;
    is_stage_d = is_stage_q;
    is_cmd_d   = is_cmd_q;
    commit     = 1'b0;
    rdata      = 32'h0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : stage_q[8*i +: 8];
    end
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d    = StAck;
          rnw_d      = OPB_RNW;
          is_stage_d = (off[31:2] == 30'd0);
          is_cmd_d   = (off[31:2] == 30'd1);
        end
      end
      StAck: begin
        state_d = StGap;
        if (rnw_q) begin
          if (is_stage_q)    rdata = stage_q;
          else if (is_cmd_q) rdata = {16'h0, cnt_q};
        end else begin
          if (is_stage_q) begin
            stage_d = merged;
            commit  = C_AUTO_COMMIT;
          end
          // Commit bit is data bit 0, carried on byte lane BE[3].
          if (is_cmd_q && be[0] && wdata[0]) commit = 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (commit) begin
      user_d   = stage_d;
      strobe_d = 1'b1;
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q    <= StIdle;
      stage_q    <= C_INIT_VALUE;
      user_q     <= C_INIT_VALUE;
      cnt_q      <= 16'h0;
      strobe_q   <= 1'b0;
      rnw_q      <= 1'b0;
      is_stage_q <= 1'b0;
      is_cmd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      user_q     <= user_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      rnw_q      <= rnw_d;
      is_stage_q <= is_stage_d;
      is_cmd_q   <= is_cmd_d;
    end
  end

  // Reset masks the ack combinationally so an aborted beat is never acknowledged.
  assign ack              = (state_q == StAck) && !OPB_Rst;
  assign Sl_xferAck       = ack;
  assign Sl_DBus          = (ack && rnw_q) ? rdata : 32'h0;
  assign Sl_errAck        = 1'b0;
  assign Sl_retry         = 1'b0;
  assign Sl_toutSup       = 1'b0;
  assign user_data_out    = user_q;
  assign user_data_strobe = strobe_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Bench for opb_register_ppc2simulink: vector table through a scoreboard queue, plus
// held-select, auto-commit wrap and reset-abort sequences.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] Base  = 32'h01028200;
  localparam logic [31:0] High  = 32'h010282FF;
  localparam logic [31:0] InitA = 32'hCAFE0001;

  typedef struct {
    bit          rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          ack;
    logic [31:0] rd;
    bit          stb;
    logic [31:0] usr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  obe = '0;
  logic [0:31] dbus = '0;
  logic rnw = 1'b0, sel_a = 1'b0, sel_b = 1'b0, seq = 1'b0;

  logic [0:31] dbus_a, dbus_b;
  logic err_a, err_b, rty_a, rty_b, tout_a, tout_b, ack_a, ack_b, stb_a, stb_b;
  logic [31:0] usr_a, usr_b;

  bit cur = 1'b0;
  logic        ack_w, stb_w;
  logic [31:0] rd_w, usr_w;
  assign ack_w = cur ? ack_b : ack_a;
  assign stb_w = cur ? stb_b : stb_a;
  assign rd_w  = cur ? dbus_b : dbus_a;
  assign usr_w = cur ? usr_b : usr_a;

  int errors = 0;
  int checks = 0;
  vec_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  opb_register_ppc2simulink #(.C_INIT_VALUE(InitA), .C_AUTO_COMMIT(1'b0)) dut_a (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(obe), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_a), .OPB_seqAddr(seq), .Sl_DBus(dbus_a),
    .Sl_errAck(err_a), .Sl_retry(rty_a), .Sl_toutSup(tout_a), .Sl_xferAck(ack_a),
    .user_data_out(usr_a), .user_data_strobe(stb_a)
  );

  opb_register_ppc2simulink #(.C_INIT_VALUE(32'h0), .C_AUTO_COMMIT(1'b1)) dut_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(obe), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_b), .OPB_seqAddr(seq), .Sl_DBus(dbus_b),
    .Sl_errAck(err_b), .Sl_retry(rty_b), .Sl_toutSup(tout_b), .Sl_xferAck(ack_b),
    .user_data_out(usr_b), .user_data_strobe(stb_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, input bit k, input logic [31:0] rd,
                              input bit s, input logic [31:0] u);
    vec_t v;
    v = '{rnw: r, addr: a, be: b, data: d, ack: k, rd: rd, stb: s, usr: u};
    return v;
  endfunction

  // One bus beat; expectations go through the scoreboard queue.
  task automatic xfer(input vec_t v, input bit which);
    vec_t e;
    int lat;
    logic [31:0] rd;
    bit idle_dbus_bad;
    sb_q.push_back(v);
    @(negedge clk);
    cur = which;
    abus = v.addr; obe = v.be; dbus = v.data; rnw = v.rnw;
    sel_a = !which; sel_b = which;
    lat = 0; rd = '0; idle_dbus_bad = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (ack_w) begin
        lat = i;
        rd = rd_w;
        break;
      end else if (rd_w != 32'h0) begin
        idle_dbus_bad = 1'b1;
      end
    end
    sel_a = 1'b0; sel_b = 1'b0;
    e = sb_q.pop_front();
    chk("ack_latency", 32'(lat), e.ack ? 32'd1 : 32'd0);
    chk("dbus_zero_no_ack", {31'h0, idle_dbus_bad}, 32'h0);
    if (e.ack && e.rnw) chk("rdata", rd, e.rd);
    @(negedge clk);
    chk("strobe_cycle2", {31'h0, stb_w}, {31'h0, e.stb});
    chk("user_data", usr_w, e.usr);
    @(negedge clk);
    chk("strobe_one_cycle", {31'h0, stb_w}, 32'h0);
  endtask

  initial begin
    int acks;
    int bad_dbus;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_user_a", usr_a, InitA);
    chk("rst_user_b", usr_b, 32'h0);
    chk("rst_strobe", {30'h0, stb_a, stb_b}, 32'h0);
    chk("rst_ack", {30'h0, ack_a, ack_b}, 32'h0);
    chk("rst_dbus", dbus_a | dbus_b, 32'h0);
    chk("tied_zero", {26'h0, err_a, err_b, rty_a, rty_b, tout_a, tout_b}, 32'h0);

    vecs.push_back(mk(1, Base + 0, 4'hF, 32'h0, 1, InitA, 0, InitA));
    vecs.push_back(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h0, 0, InitA));
    vecs.push_back(mk(0, Base + 0, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0, InitA));
    vecs.push_back(mk(0, Base + 0, 4'b0100, 32'h00AA0000, 1, 32'h0, 0, InitA));
    vecs.push_back(mk(1, Base + 0, 4'hF, 32'h0, 1, 32'hDEAABEEF, 0, InitA));
    vecs.push_back(mk(0, Base + 4, 4'hF, 32'h1, 1, 32'h0, 1, 32'hDEAABEEF));
    vecs.push_back(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h1, 0, 32'hDEAABEEF));
    vecs.push_back(mk(0, Base + 4, 4'hF, 32'h0, 1, 32'h0, 0, 32'hDEAABEEF));
    vecs.push_back(mk(0, Base + 4, 4'b1110, 32'hFFFFFFFF, 1, 32'h0, 0, 32'hDEAABEEF));
    vecs.push_back(mk(1, Base + 8, 4'hF, 32'h0, 1, 32'h0, 0, 32'hDEAABEEF));
    vecs.push_back(mk(0, Base + 8, 4'hF, 32'hFFFFFFFF, 1, 32'h0, 0, 32'hDEAABEEF));
    vecs.push_back(mk(0, Base + 0, 4'b1001, 32'h11223344, 1, 32'h0, 0, 32'hDEAABEEF));
    vecs.push_back(mk(1, Base + 0, 4'hF, 32'h0, 1, 32'h11AABE44, 0, 32'hDEAABEEF));
    vecs.push_back(mk(0, Base + 4, 4'hF, 32'h1, 1, 32'h0, 1, 32'h11AABE44));
    vecs.push_back(mk(0, Base + 4, 4'hF, 32'h1, 1, 32'h0, 1, 32'h11AABE44));
    vecs.push_back(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h3, 0, 32'h11AABE44));
    vecs.push_back(mk(0, High - 3, 4'hF, 32'h5555AAAA, 1, 32'h0, 0, 32'h11AABE44));
    vecs.push_back(mk(1, High - 3, 4'hF, 32'h0, 1, 32'h0, 0, 32'h11AABE44));
    vecs.push_back(mk(1, High + 4, 4'hF, 32'h0, 0, 32'h0, 0, 32'h11AABE44));
    vecs.push_back(mk(1, Base - 4, 4'hF, 32'h0, 0, 32'h0, 0, 32'h11AABE44));
    vecs.push_back(mk(0, High + 1, 4'hF, 32'h0, 0, 32'h0, 0, 32'h11AABE44));
    vecs.push_back(mk(1, Base + 0, 4'hF, 32'h0, 1, 32'h11AABE44, 0, 32'h11AABE44));
    for (int i = 0; i < vecs.size(); i++) xfer(vecs[i], 1'b0);

    // Held select: one beat per three cycles
    @(negedge clk);
    cur = 1'b0;
    abus = Base; obe = 4'hF; rnw = 1'b1; sel_a = 1'b1;
    acks = 0; bad_dbus = 0;
    repeat (9) begin
      @(negedge clk);
      if (ack_a) acks++;
      else if (dbus_a != 32'h0) bad_dbus++;
    end
    sel_a = 1'b0;
    chk("held_select_acks", 32'(acks), 32'd3);
    chk("held_select_dbus_idle", 32'(bad_dbus), 32'd0);
    repeat (3) @(negedge clk);

    // Auto-commit and counter wrap
    xfer(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h0, 0, 32'h0), 1'b1);
    @(negedge clk);
    dut_b.cnt_q = 16'hFFFF;
    xfer(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h0000FFFF, 0, 32'h0), 1'b1);
    xfer(mk(0, Base + 0, 4'hF, 32'h12345678, 1, 32'h0, 1, 32'h12345678), 1'b1);
    xfer(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h0, 0, 32'h12345678), 1'b1);
    xfer(mk(0, Base + 0, 4'b0011, 32'h0000AAAA, 1, 32'h0, 1, 32'h1234AAAA), 1'b1);
    xfer(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h1, 0, 32'h1234AAAA), 1'b1);

    // Reset in the ACK cycle of a commit write aborts it
    @(negedge clk);
    cur = 1'b0;
    abus = Base + 4; obe = 4'hF; dbus = 32'h1; rnw = 1'b0; sel_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_a) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_ack_seen", {31'h0, got}, 32'h1);
    rst = 1'b1; sel_a = 1'b0;
    @(negedge clk);
    chk("abort_strobe", {31'h0, stb_a}, 32'h0);
    chk("abort_user", usr_a, InitA);
    chk("abort_ack", {31'h0, ack_a}, 32'h0);
    chk("abort_dbus", dbus_a, 32'h0);
    chk("abort_user_b", usr_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    xfer(mk(1, Base + 0, 4'hF, 32'h0, 1, InitA, 0, InitA), 1'b0);
    xfer(mk(1, Base + 4, 4'hF, 32'h0, 1, 32'h0, 0, InitA), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
